uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Param CLKS_PER_BIT, default 234, clk cycles per UART bit (27 MHz / 115200); legal >= 2.
REQ-002 Param DATA_BITS, default 8, data bits per frame; legal 5..8.
REQ-003 Param PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Param STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-005 Param FIFO_DEPTH, default 16, transmit FIFO entries; power of two, >= 2.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_data  in  DATA_BITS  byte to transmit, LSB sent first.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  FIFO can accept; high iff fifo_count < FIFO_DEPTH.
REQ-011 uart_tx  out  1  serial line, registered, idle high.
REQ-012 busy  out  1  high when FSM not IDLE.
REQ-013 tx_done  out  1  one-cycle pulse on the edge the final stop bit ends.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Push on edge where in_valid && in_ready; in_data held by source until then.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: uart_tx=1; if FIFO non-empty, pop head into shift register, go START, same edge.
REQ-018 Each bit holds uart_tx for exactly CLKS_PER_BIT cycles via bit counter 0..CLKS_PER_BIT-1, wrapping to 0 on each bit boundary.
REQ-019 START drives 0; DATA drives DATA_BITS bits LSB first; PARITY (skipped if PARITY=0) drives XOR of data bits for even, inverted for odd; STOP drives 1 for STOP_BITS bit periods.
REQ-020 Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles exactly.
REQ-021 Latency: push at edge E0 into empty FIFO with FSM IDLE -> pop at E1, uart_tx=0 after E1.
REQ-022 End of STOP with FIFO non-empty: pop and enter START on same edge; no idle cycle between frames.
REQ-023 End of STOP with FIFO empty: go IDLE; tx_done pulses on that edge either way.
REQ-024 Simultaneous push and pop: fifo_count unchanged, both take effect.
REQ-025 Full: in_ready=0; in_valid ignored; no overwrite. Empty: no pop, FSM stays IDLE.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; order strictly FIFO.

Reset
REQ-027 rst at any edge, including mid-frame: uart_tx=1, FSM=IDLE, counters 0, FIFO emptied (fifo_count=0), busy=0, tx_done=0, in_ready=1 after that edge.
REQ-028 An in-progress frame is abandoned on rst; no tx_done issued for it.

Structure
REQ-029 Package uart_pkg holds FSM state enum and PARITY_NONE/ODD/EVEN constants.
REQ-030 Sub-module uart_byte_fifo (synchronous FIFO, width DATA_BITS, depth FIFO_DEPTH, count output) instantiated once.

Verification (bench CLKS_PER_BIT=4)
REQ-031 Reset: after rst edge -> uart_tx=1, in_ready=1, busy=0, fifo_count=0, tx_done=0.
REQ-032 8N1, push 0x55 -> uart_tx low from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; 40 cycles total; one tx_done.
REQ-033 8E1 push 0x07 -> parity bit 1; 8O1 push 0x07 -> parity bit 0; frame 44 cycles.
REQ-034 FIFO_DEPTH=4, in_valid held with 0x01..0x06 -> in_ready low when fifo_count=4; six contiguous frames in order 0x01..0x06, no idle gap; six tx_done pulses.
REQ-035 7N2 push 0x7F -> 7 data ones, 2 stop bits; frame 40 cycles.
REQ-036 rst during DATA bit 3 with 2 bytes queued -> uart_tx=1 next edge, fifo_count=0, no tx_done, line stays idle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Parity bit for a data word; odd mode inverts the plain XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with occupancy count; combinational read of the head entry.
module uart_byte_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  // Handshakes, pointer advance (wraps modulo Depth) and occupancy update.
  always_comb begin
    push     = wr_valid_i && (count_q != Full);
    pop      = rd_en_i && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign wr_ready_o = (count_q != Full);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frames are sent back to back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IdxMax = 3'(DATA_BITS - 1);
  localparam logic StopMax = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 pop, load, bit_end, fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  uart_byte_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_data_i  (in_data),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_data),
    .count_o    (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);

  // Frame sequencing; the line level is derived from the next state so uart_tx is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    load    = 1'b0;
    bit_end = (cnt_q == CntMax);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxMax) begin
            state_d = (PARITY == PARITY_NONE) ? StStop : StParity;
            stop_d  = 1'b0;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopMax) begin
            done_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pop the head and start a new frame on the same edge.
    if (load) begin
      state_d = StStart;
      cnt_d   = '0;
      shift_d = fifo_data;
      par_d   = parity_bit(8'(fifo_data), PARITY);
    end
    pop = load;

    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state_q != StIdle);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four transmitter configurations, table-driven frames plus corner sequences.
module tb_uart_tx_fifo;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8N1, depth 4
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_ready, a_tx, a_busy, a_done;
  logic [2:0] a_count;
  // 8E1 and 8O1
  logic [7:0] p_data = '0;
  logic       e_valid = 1'b0, e_ready, e_tx, e_busy, e_done;
  logic       o_valid = 1'b0, o_ready, o_tx, o_busy, o_done;
  logic [4:0] e_count, o_count;
  // 7N2
  logic [6:0] s_data = '0;
  logic       s_valid = 1'b0, s_ready, s_tx, s_busy, s_done;
  logic [4:0] s_count;

  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
  u_8n1 (.clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
         .uart_tx(a_tx), .busy(a_busy), .tx_done(a_done), .fifo_count(a_count));

  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
  u_8e1 (.clk(clk), .rst(rst), .in_data(p_data), .in_valid(e_valid), .in_ready(e_ready),
         .uart_tx(e_tx), .busy(e_busy), .tx_done(e_done), .fifo_count(e_count));

  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
  u_8o1 (.clk(clk), .rst(rst), .in_data(p_data), .in_valid(o_valid), .in_ready(o_ready),
         .uart_tx(o_tx), .busy(o_busy), .tx_done(o_done), .fifo_count(o_count));

  uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
  u_7n2 (.clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
         .uart_tx(s_tx), .busy(s_busy), .tx_done(s_done), .fifo_count(s_count));

  int sel = 0;
  logic mon_tx, mon_done, mon_busy;

  // Route the selected instance to the frame monitor.
  always_comb begin
    mon_tx = 1'b1; mon_done = 1'b0; mon_busy = 1'b0;
    case (sel)
      0:       begin mon_tx = a_tx; mon_done = a_done; mon_busy = a_busy; end
      1:       begin mon_tx = e_tx; mon_done = e_done; mon_busy = e_busy; end
      2:       begin mon_tx = o_tx; mon_done = o_done; mon_busy = o_busy; end
      default: begin mon_tx = s_tx; mon_done = s_done; mon_busy = s_busy; end
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame line bits listed start-bit first (bit 0 = start).
  typedef struct {
    int         sel;
    logic [7:0] data;
    int         nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[10];

  task automatic push_byte(input int s, input logic [7:0] d);
    @(negedge clk);
    case (s)
      0:       begin a_data = d; a_valid = 1'b1; end
      1:       begin p_data = d; e_valid = 1'b1; end
      2:       begin p_data = d; o_valid = 1'b1; end
      default: begin s_data = d[6:0]; s_valid = 1'b1; end
    endcase
    @(negedge clk);
    a_valid = 1'b0; e_valid = 1'b0; o_valid = 1'b0; s_valid = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of nframes contiguous frames against exp_q.
  task automatic check_stream(input string name, input int nframes, input int nbits);
    int   t = 0;
    logic e, got, bad, dbad;
    while (mon_tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, " start seen"}, 32'(mon_tx), 32'(0));
    if (mon_tx !== 1'b0) begin
      exp_q.delete();
      return;
    end
    dbad = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      for (int b = 0; b < nbits; b++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        bad = 1'b0;
        got = 1'b0;
        for (int c = 0; c < Cpb; c++) begin
          if (!bad) got = mon_tx;
          if (mon_tx !== e) bad = 1'b1;
          if (mon_done !== ((f > 0 && b == 0 && c == 0) ? 1'b1 : 1'b0)) dbad = 1'b1;
          @(negedge clk);
        end
        check($sformatf("%s frame%0d bit%0d", name, f, b), 32'(got), 32'(e));
      end
    end
    check({name, " tx_done placement"}, 32'(dbad), 32'(0));
    check({name, " final tx_done"}, 32'(mon_done), 32'(1));
    check({name, " idle after"}, {30'd0, mon_tx, mon_busy}, 32'b10);
  endtask

  initial begin
    logic rdy, saw_full, bad_full;
    int   guard;

    vecs[0] = '{0, 8'h55, 10, 12'(10'b1_01010101_0)};
    vecs[1] = '{0, 8'h00, 10, 12'(10'b1_00000000_0)};
    vecs[2] = '{0, 8'hFF, 10, 12'(10'b1_11111111_0)};
    vecs[3] = '{0, 8'hA3, 10, 12'(10'b1_10100011_0)};
    vecs[4] = '{1, 8'h07, 11, 12'(11'b1_1_00000111_0)};
    vecs[5] = '{2, 8'h07, 11, 12'(11'b1_0_00000111_0)};
    vecs[6] = '{1, 8'h00, 11, 12'(11'b1_0_00000000_0)};
    vecs[7] = '{2, 8'h00, 11, 12'(11'b1_1_00000000_0)};
    vecs[8] = '{3, 8'h7F, 10, 12'(10'b11_1111111_0)};
    vecs[9] = '{3, 8'h2A, 10, 12'(10'b11_0101010_0)};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst 8n1 outs", {27'd0, a_tx, a_ready, a_busy, a_done, 1'b0}, {27'd0, 5'b11000});
    check("rst 8n1 count", 32'(a_count), 32'(0));
    check("rst 8e1 outs", {28'd0, e_tx, e_ready, e_busy, e_done}, 32'b1100);
    check("rst 8o1 outs", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
    check("rst 7n2 outs", {28'd0, s_tx, s_ready, s_busy, s_done}, 32'b1100);
    check("rst counts", {e_count, o_count, s_count}, 32'(0));
    rst = 1'b0;

    // Table-driven single frames
    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].sel;
      exp_q.delete();
      for (int k = 0; k < vecs[i].nbits; k++) exp_q.push_back(vecs[i].frame[k]);
      push_byte(vecs[i].sel, vecs[i].data);
      if (i == 0) begin
        check("latency E0 tx/count", {28'd0, a_tx, a_count}, {28'd0, 1'b1, 3'd1});
        @(negedge clk);
        check("latency E1 tx/busy/count", {27'd0, a_tx, a_busy, a_count}, {27'd0, 2'b01, 3'd0});
      end
      check_stream($sformatf("vec%0d", i), 1, vecs[i].nbits);
    end

    // Depth-4 FIFO held full, six back-to-back frames
    sel = 0;
    exp_q.delete();
    saw_full = 1'b0;
    bad_full = 1'b0;
    fork
      begin
        @(negedge clk);
        for (int n = 1; n <= 6; n++) begin
          a_data = 8'(n);
          a_valid = 1'b1;
          exp_q.push_back(1'b0);
          for (int k = 0; k < 8; k++) exp_q.push_back(a_data[k]);
          exp_q.push_back(1'b1);
          guard = 0;
          do begin
            rdy = a_ready;
            if (a_count == 3'd4) saw_full = 1'b1;
            if (a_count == 3'd4 && a_ready) bad_full = 1'b1;
            if (a_count > 3'd4) bad_full = 1'b1;
            @(negedge clk);
            guard++;
          end while (!rdy && guard < 500);
        end
        a_valid = 1'b0;
      end
      check_stream("burst", 6, 10);
    join
    check("burst saw full", 32'(saw_full), 32'(1));
    check("burst ready when full", 32'(bad_full), 32'(0));
    check("burst empty after", 32'(a_count), 32'(0));

    // Reset mid-frame with two bytes queued
    @(negedge clk);
    a_data = 8'hC3; a_valid = 1'b1;
    @(negedge clk);
    a_data = 8'h3C;
    @(negedge clk);
    a_data = 8'h99;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("pre-rst count/busy", {28'd0, a_busy, a_count}, {28'd0, 1'b1, 3'd2});
    rst = 1'b1;
    @(negedge clk);
    check("post-rst outs", {27'd0, a_tx, a_ready, a_busy, a_done, 1'b0}, {27'd0, 5'b11000});
    check("post-rst count", 32'(a_count), 32'(0));
    rst = 1'b0;
    bad_full = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) bad_full = 1'b1;
    end
    check("post-rst line idle", 32'(bad_full), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
